mul_rs_dispatch: RTL and testbench
==================================

Name: mul_rs_dispatch

Overview:
- Multiply/divide reservation station: the issue-side initiator that feeds the mul/div functional unit, and the consumer of that unit's result broadcast.
- Accepts decoded mul/div ops from issue and holds them until both operands are valid.
- Snoops the common data bus (CDB) for tagged results and dispatches one ready entry per cycle to the unit through a valid/ready handshake.
- Replaces direct hierarchical writes into the station arrays and the hierarchical `mul_rs_c` decrement with a single owning block.

Parameters:
- XLEN, 32, operand/result width
- TAG_W, 3, ROB tag width (destination and source tags)
- DEPTH, 3, number of station entries
- CNT_W, 2, occupancy counter width (must hold DEPTH)

Ports:
- clk1  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  synchronous clear of all entries (mispredict)
- alloc_valid  in  1  issue presents new op
- alloc_ready  out  1  free entry available
- alloc_fun3  in  3  0 = mul, 1 = div; other codes rejected (entry not written, alloc_err pulses)
- alloc_des  in  TAG_W  destination ROB tag
- alloc_rdy1 / alloc_rdy2  in  1  operand already valid
- alloc_val1 / alloc_val2  in  XLEN  operand values (used when rdy)
- alloc_tag1 / alloc_tag2  in  TAG_W  producer tags (used when !rdy)
- alloc_err  out  1  one-cycle pulse on illegal fun3
- cdb_valid  in  1  result broadcast valid
- cdb_tag  in  TAG_W  broadcast ROB tag
- cdb_data  in  XLEN  broadcast value
- fu_valid  out  1  dispatch request to mul/div unit
- fu_ready  in  1  unit idle, accepts this cycle
- fu_data1 / fu_data2  out  XLEN  operands
- fu_fun3  out  3  op code
- fu_des  out  TAG_W  destination tag
- mul_rs_c  out  CNT_W  occupied entries

Behaviour:
- Reset (rst_n = 0 at edge): all busy/ready bits cleared, mul_rs_c = 0, fu_valid = 0, alloc_err = 0. fu_data*, fu_fun3 and fu_des are driven to 0.
- flush has the same effect as reset on entries and the counter. It overrides alloc and dispatch in the same cycle.
- Per-entry state: busy, fun3, des, rdy1/val1/tag1, rdy2/val2/tag2.
- alloc_ready = (mul_rs_c < DEPTH), computed from registered state only. An entry freed by dispatch in cycle N is allocatable in cycle N+1.
- Allocation (alloc_valid & alloc_ready, legal fun3): write the lowest-index free entry.
- Same-cycle CDB bypass: if an operand has !rdy and cdb_valid & cdb_tag == tag, the entry captures cdb_data with rdy = 1. This is required; without it the operand would miss the broadcast.
- Wakeup: every busy entry with rdyX = 0 and tagX == cdb_tag under cdb_valid latches cdb_data and sets rdyX. Both operands may wake in one cycle.
- Eligibility: busy & rdy1 & rdy2, using registered state. An entry woken at edge N is eligible for selection from edge N onward.
- Selection and dispatch:
  - Combinational select picks one eligible entry.
  - fu_valid is high while any entry is eligible.
  - fu_* outputs show the selected entry; they are stable while fu_valid & !fu_ready.
  - Transfer occurs on fu_valid & fu_ready: the entry's busy bit is cleared at that edge.
- Counter update: mul_rs_c += alloc accepted, −= dispatch accepted. Simultaneous alloc and dispatch leave it unchanged. It never wraps; an alloc when full is impossible by construction.
- fu_ready high with no eligible entry: no action.
- A CDB tag matching no waiting operand is ignored.
- Illegal fun3 (≥2): alloc_err = 1 for one cycle and no entry is consumed.

Optional Feature:
- Macro MUL_RS_AGE_EN.
- Defined: each entry carries an age rank (0 = oldest). Select picks the eligible entry with the lowest rank. Ranks are compacted on dispatch, and a new entry gets rank = current mul_rs_c.
- Undefined: select picks the lowest-index eligible entry. No age state is built.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles, then release → mul_rs_c = 0, alloc_ready = 1, fu_valid = 0.
- Ready alloc: alloc mul with val1 = 6, val2 = 7, both rdy, fu_ready = 1 → next cycle fu_valid = 1, fu_data1 = 6, fu_data2 = 7, fu_fun3 = 0; count goes 1 → 0 after the transfer.
- Wakeup: alloc div with tag1 = 3 (not ready), val2 = 4 ready; later cdb_valid, tag = 3, data = 100 → fu_valid asserts from the next cycle, fu_data1 = 100, fu_fun3 = 1.
- Same-cycle bypass: alloc with tag2 = 5 while cdb_valid, tag = 5, data = 9 → entry eligible next cycle with fu_data2 = 9.
- Full/backpressure: 3 allocs with fu_ready = 0 → alloc_ready = 0, mul_rs_c = 3, fu_* held stable. Raise fu_ready for one cycle and alloc simultaneously → that alloc is not accepted; alloc_ready = 1 on the next cycle.
- Order and flush: two entries become ready in the same cycle in index order 1, 0, with entry 1 older → with MUL_RS_AGE_EN entry 1 dispatches first, without it entry 0 dispatches first. Then assert flush with alloc_valid → mul_rs_c = 0, no entry written.

Source files
------------

// File: rtl/mul_rs_dispatch.sv
// rtl/mul_rs_dispatch.sv - mul/div reservation station; optional age select under MUL_RS_AGE_EN
module mul_rs_dispatch #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 3,
  parameter int DEPTH = 3,
  parameter int CNT_W = 2
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic [2:0]       alloc_fun3,
  input  logic [TAG_W-1:0] alloc_des,
  input  logic             alloc_rdy1,
  input  logic             alloc_rdy2,
  input  logic [XLEN-1:0]  alloc_val1,
  input  logic [XLEN-1:0]  alloc_val2,
  input  logic [TAG_W-1:0] alloc_tag1,
  input  logic [TAG_W-1:0] alloc_tag2,
  output logic             alloc_err,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
  output logic             fu_valid,
  input  logic             fu_ready,
  output logic [XLEN-1:0]  fu_data1,
  output logic [XLEN-1:0]  fu_data2,
  output logic [2:0]       fu_fun3,
  output logic [TAG_W-1:0] fu_des,
  output logic [CNT_W-1:0] mul_rs_c
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DEPTH-1:0] busy_q, busy_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [2:0]       fun3_q [DEPTH];
  logic [2:0]       fun3_d [DEPTH];
  logic [TAG_W-1:0] des_q  [DEPTH];
  logic [TAG_W-1:0] des_d  [DEPTH];
  logic [TAG_W-1:0] tag1_q [DEPTH];
  logic [TAG_W-1:0] tag1_d [DEPTH];
  logic [TAG_W-1:0] tag2_q [DEPTH];
  logic [TAG_W-1:0] tag2_d [DEPTH];
  logic [XLEN-1:0]  val1_q [DEPTH];
  logic [XLEN-1:0]  val1_d [DEPTH];
  logic [XLEN-1:0]  val2_q [DEPTH];
  logic [XLEN-1:0]  val2_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  // Lock keeps the offered entry fixed while the unit stalls, so a late wakeup cannot swap it
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
`ifdef MUL_RS_AGE_EN
  logic [CNT_W-1:0] age_q [DEPTH];
  logic [CNT_W-1:0] age_d [DEPTH];
  logic [CNT_W-1:0] best_age;
`endif

  logic [DEPTH-1:0] elig;
  logic             found, free_found;
  logic [IDX_W-1:0] sel, free_idx;
  logic             legal, alloc_ok, disp;

  // Select the entry offered to the unit and the lowest free slot, from registered state only
  always_comb begin
    elig       = busy_q & rdy1_q & rdy2_q;
    found      = 1'b0;
    sel        = '0;
    free_found = 1'b0;
    free_idx   = '0;
`ifdef MUL_RS_AGE_EN
    best_age   = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
`ifdef MUL_RS_AGE_EN
      if (elig[i] && (!found || age_q[i] < best_age)) begin
        found    = 1'b1;
        sel      = IDX_W'(i);
        best_age = age_q[i];
      end
`else
      if (elig[i] && !found) begin
        found = 1'b1;
        sel   = IDX_W'(i);
      end
`endif
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    if (lock_q) sel = lock_idx_q;
  end

  assign alloc_ready = (cnt_q < DEPTH_C);
  assign fu_valid    = |elig;
  assign fu_data1    = fu_valid ? val1_q[sel] : '0;
  assign fu_data2    = fu_valid ? val2_q[sel] : '0;
  assign fu_fun3     = fu_valid ? fun3_q[sel] : '0;
  assign fu_des      = fu_valid ? des_q[sel]  : '0;
  assign mul_rs_c    = cnt_q;
  assign alloc_err   = err_q;

  assign legal    = (alloc_fun3 < 3'd2);
  assign alloc_ok = alloc_valid & alloc_ready & legal;
  assign disp     = fu_valid & fu_ready;

  // Next state: wakeup, dispatch, allocation with CDB bypass, counter; flush overrides all
  always_comb begin
    busy_d = busy_q;
    rdy1_d = rdy1_q;
    rdy2_d = rdy2_q;
    fun3_d = fun3_q;
    des_d  = des_q;
    tag1_d = tag1_q;
    tag2_d = tag2_q;
    val1_d = val1_q;
    val2_d = val2_q;
`ifdef MUL_RS_AGE_EN
    age_d  = age_q;
`endif
    cnt_d      = cnt_q;
    err_d      = alloc_valid & alloc_ready & !legal;
    lock_d     = fu_valid & !fu_ready;
    lock_idx_d = sel;

    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_valid && busy_q[i] && !rdy1_q[i] && tag1_q[i] == cdb_tag) begin
        rdy1_d[i] = 1'b1;
        val1_d[i] = cdb_data;
      end
      if (cdb_valid && busy_q[i] && !rdy2_q[i] && tag2_q[i] == cdb_tag) begin
        rdy2_d[i] = 1'b1;
        val2_d[i] = cdb_data;
      end
`ifdef MUL_RS_AGE_EN
      if (disp && busy_q[i] && age_q[i] > age_q[sel]) age_d[i] = age_q[i] - CNT_W'(1);
`endif
    end

    if (disp) busy_d[sel] = 1'b0;

    if (alloc_ok) begin
      busy_d[free_idx] = 1'b1;
      fun3_d[free_idx] = alloc_fun3;
      des_d[free_idx]  = alloc_des;
      tag1_d[free_idx] = alloc_tag1;
      tag2_d[free_idx] = alloc_tag2;
      rdy1_d[free_idx] = alloc_rdy1 | (cdb_valid && alloc_tag1 == cdb_tag);
      rdy2_d[free_idx] = alloc_rdy2 | (cdb_valid && alloc_tag2 == cdb_tag);
      val1_d[free_idx] = alloc_rdy1 ? alloc_val1 : cdb_data;
      val2_d[free_idx] = alloc_rdy2 ? alloc_val2 : cdb_data;
`ifdef MUL_RS_AGE_EN
      // Newest rank is the occupancy, shifted down when an older entry leaves this cycle
      age_d[free_idx]  = disp ? cnt_q - CNT_W'(1) : cnt_q;
`endif
    end

    case ({alloc_ok, disp})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    if (flush) begin
      busy_d = '0;
      rdy1_d = '0;
      rdy2_d = '0;
      cnt_d  = '0;
      err_d  = 1'b0;
      lock_d = 1'b0;
    end
  end

  // Control state is reset; payload arrays only matter while busy so they are not
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      busy_q     <= '0;
      rdy1_q     <= '0;
      rdy2_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      busy_q     <= busy_d;
      rdy1_q     <= rdy1_d;
      rdy2_q     <= rdy2_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
    fun3_q <= fun3_d;
    des_q  <= des_d;
    tag1_q <= tag1_d;
    tag2_q <= tag2_d;
    val1_q <= val1_d;
    val2_q <= val2_d;
`ifdef MUL_RS_AGE_EN
    age_q  <= age_d;
`endif
  end

endmodule

// File: tb/tb_mul_rs_dispatch.sv
// tb/tb_mul_rs_dispatch.sv - directed self-checking bench for mul_rs_dispatch
module tb_mul_rs_dispatch;

  logic        clk1 = 1'b0;
  logic        rst_n, flush;
  logic        alloc_valid, alloc_ready, alloc_rdy1, alloc_rdy2, alloc_err;
  logic [2:0]  alloc_fun3;
  logic [2:0]  alloc_des, alloc_tag1, alloc_tag2;
  logic [31:0] alloc_val1, alloc_val2;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        fu_valid, fu_ready;
  logic [31:0] fu_data1, fu_data2;
  logic [2:0]  fu_fun3, fu_des;
  logic [1:0]  mul_rs_c;

  int checks = 0;
  int errors = 0;

  always #5 clk1 = ~clk1;

  mul_rs_dispatch dut (
    .clk1(clk1), .rst_n(rst_n), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_fun3(alloc_fun3),
    .alloc_des(alloc_des), .alloc_rdy1(alloc_rdy1), .alloc_rdy2(alloc_rdy2),
    .alloc_val1(alloc_val1), .alloc_val2(alloc_val2),
    .alloc_tag1(alloc_tag1), .alloc_tag2(alloc_tag2), .alloc_err(alloc_err),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_data1(fu_data1), .fu_data2(fu_data2),
    .fu_fun3(fu_fun3), .fu_des(fu_des), .mul_rs_c(mul_rs_c)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic alloc(input logic [2:0] f, input logic [2:0] d,
                       input logic r1, input logic [31:0] v1, input logic [2:0] t1,
                       input logic r2, input logic [31:0] v2, input logic [2:0] t2);
    alloc_valid = 1'b1;
    alloc_fun3  = f;
    alloc_des   = d;
    alloc_rdy1  = r1;
    alloc_val1  = v1;
    alloc_tag1  = t1;
    alloc_rdy2  = r2;
    alloc_val2  = v2;
    alloc_tag2  = t2;
  endtask

  task automatic cdb(input logic [2:0] t, input logic [31:0] d);
    cdb_valid = 1'b1;
    cdb_tag   = t;
    cdb_data  = d;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    cdb_valid   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; fu_ready = 1'b0;
    alloc_valid = 1'b0; alloc_fun3 = '0; alloc_des = '0;
    alloc_rdy1 = 1'b0; alloc_rdy2 = 1'b0; alloc_val1 = '0; alloc_val2 = '0;
    alloc_tag1 = '0; alloc_tag2 = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;

    tick(); tick();
    rst_n = 1'b1;
    chk("rst_cnt", mul_rs_c, 0);
    chk("rst_ready", alloc_ready, 1);
    chk("rst_fu_valid", fu_valid, 0);
    chk("rst_err", alloc_err, 0);
    chk("rst_fu_data1", fu_data1, 0);

    // ready mul goes straight out
    fu_ready = 1'b1;
    alloc(3'd0, 3'd1, 1'b1, 32'd6, 3'd0, 1'b1, 32'd7, 3'd0);
    tick(); idle();
    chk("rdy_valid", fu_valid, 1);
    chk("rdy_d1", fu_data1, 6);
    chk("rdy_d2", fu_data2, 7);
    chk("rdy_fun3", fu_fun3, 0);
    chk("rdy_des", fu_des, 1);
    chk("rdy_cnt1", mul_rs_c, 1);
    tick();
    chk("rdy_cnt0", mul_rs_c, 0);
    chk("rdy_empty", fu_valid, 0);

    // div waits for tag 3; unrelated tag 6 ignored
    alloc(3'd1, 3'd2, 1'b0, 32'd0, 3'd3, 1'b1, 32'd4, 3'd0);
    tick(); idle();
    chk("wk_wait", fu_valid, 0);
    chk("wk_cnt", mul_rs_c, 1);
    cdb(3'd6, 32'd55);
    tick(); idle();
    chk("wk_nomatch", fu_valid, 0);
    cdb(3'd3, 32'd100);
    tick(); idle();
    chk("wk_valid", fu_valid, 1);
    chk("wk_d1", fu_data1, 100);
    chk("wk_d2", fu_data2, 4);
    chk("wk_fun3", fu_fun3, 1);
    tick();
    chk("wk_cnt0", mul_rs_c, 0);

    // illegal fun3
    fu_ready = 1'b0;
    alloc(3'd2, 3'd1, 1'b1, 32'd1, 3'd0, 1'b1, 32'd1, 3'd0);
    tick(); idle();
    chk("ill_err", alloc_err, 1);
    chk("ill_cnt", mul_rs_c, 0);
    tick();
    chk("ill_err_pulse", alloc_err, 0);

    // same-cycle bypass on operand 2
    alloc(3'd0, 3'd2, 1'b1, 32'd2, 3'd0, 1'b0, 32'd0, 3'd5);
    cdb(3'd5, 32'd9);
    tick(); idle();
    chk("byp_valid", fu_valid, 1);
    chk("byp_d1", fu_data1, 2);
    chk("byp_d2", fu_data2, 9);

    // fill under backpressure
    alloc(3'd0, 3'd3, 1'b1, 32'd10, 3'd0, 1'b1, 32'd11, 3'd0);
    tick();
    chk("full_cnt2", mul_rs_c, 2);
    chk("full_rdy2", alloc_ready, 1);
    alloc(3'd1, 3'd4, 1'b1, 32'd20, 3'd0, 1'b1, 32'd21, 3'd0);
    tick(); idle();
    chk("full_cnt3", mul_rs_c, 3);
    chk("full_rdy0", alloc_ready, 0);
    chk("full_hold_d2", fu_data2, 9);
    tick();
    chk("full_hold_d1", fu_data1, 2);
    fu_ready = 1'b1;
    alloc(3'd0, 3'd5, 1'b1, 32'd50, 3'd0, 1'b1, 32'd51, 3'd0);
    tick(); idle(); fu_ready = 1'b0;
    chk("full_rej_cnt", mul_rs_c, 2);
    chk("full_rdy_back", alloc_ready, 1);
    chk("full_next_d1", fu_data1, 10);
    fu_ready = 1'b1;
    tick();
    chk("drain_d1", fu_data1, 20);
    chk("drain_cnt", mul_rs_c, 1);
    tick(); fu_ready = 1'b0;
    chk("drain_cnt0", mul_rs_c, 0);
    chk("drain_empty", fu_valid, 0);

    // age order: entry 1 older than re-used entry 0, both wake together
    alloc(3'd0, 3'd5, 1'b1, 32'd30, 3'd0, 1'b1, 32'd31, 3'd0);
    tick();
    alloc(3'd1, 3'd6, 1'b0, 32'd0, 3'd2, 1'b1, 32'd40, 3'd0);
    tick(); idle();
    fu_ready = 1'b1;
    tick(); fu_ready = 1'b0;
    chk("ord_cnt1", mul_rs_c, 1);
    chk("ord_none", fu_valid, 0);
    alloc(3'd0, 3'd7, 1'b0, 32'd0, 3'd2, 1'b1, 32'd50, 3'd0);
    tick(); idle();
    chk("ord_cnt2", mul_rs_c, 2);
    cdb(3'd2, 32'd77);
    tick(); idle();
    chk("ord_valid", fu_valid, 1);
`ifdef MUL_RS_AGE_EN
    chk("ord_first", fu_des, 6);
`else
    chk("ord_first", fu_des, 7);
`endif
    chk("ord_d1", fu_data1, 77);
    fu_ready = 1'b1;
    tick();
`ifdef MUL_RS_AGE_EN
    chk("ord_second", fu_des, 7);
`else
    chk("ord_second", fu_des, 6);
`endif
    tick(); fu_ready = 1'b0;
    chk("ord_cnt0", mul_rs_c, 0);

    // flush overrides alloc
    alloc(3'd0, 3'd1, 1'b1, 32'd3, 3'd0, 1'b1, 32'd3, 3'd0);
    tick();
    chk("fl_pre_cnt", mul_rs_c, 1);
    flush = 1'b1;
    tick(); flush = 1'b0; idle();
    chk("fl_cnt", mul_rs_c, 0);
    chk("fl_valid", fu_valid, 0);
    chk("fl_ready", alloc_ready, 1);
    tick();
    chk("fl_nowrite", fu_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
